fnd_scan_controller: RTL

//   Multiplexed N-digit 7-segment (FND) driver. Holds a shadow copy of the digit

---
 rtl/fnd_pkg.sv | 15 +
 rtl/fnd_hex_font.sv | 11 +
 rtl/fnd_scan_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: blank pattern, decimal-point bit
// and the active-low hex font table (segment order {dp,g,f,e,d,c,b,a}).
package fnd_pkg;

  localparam logic [7:0] FND_FONT_BLANK = 8'hff;
  localparam int         DP_BIT         = 7;

  localparam logic [7:0] FND_HEX_FONT [16] = '{
    8'hc0, 8'hf9, 8'ha4, 8'hb0,
    8'h99, 8'h92, 8'h82, 8'hf8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hc6, 8'ha1, 8'h86, 8'h8e
  };

endpackage

// File: rtl/fnd_hex_font.sv
// Combinational hex nibble to active-low 7-segment font decoder (dp bit left off).
module fnd_hex_font
  import fnd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_font
);

  assign o_font = FND_HEX_FONT[i_nibble];

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed N-digit 7-segment scan driver with dead time between digit slots.
// Optional build macro FND_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_COUNT   = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_load,
  output logic [NUM_DIGITS-1:0]   o_fndCom,
  output logic [7:0]              o_fndFont,
  output logic [2:0]              o_digitIdx
);

  localparam int PRESC_W = $clog2(DIV_COUNT);

  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic [7:0]              font_q, font_d;

  logic                    presc_tc;
  logic [3:0]              nibble_sel;
  logic                    dp_sel;
  logic                    blank_sel;
  logic                    lz_sel;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [7:0]              hex_font;

  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (i_load) begin
      value_d = i_value;
      dp_d    = i_dp;
      blank_d = i_blank;
    end
  end

  // Loads only touch the shadow regs; the scan timing runs independently.
  always_comb begin
    presc_tc = (presc_q == PRESC_W'(DIV_COUNT - 1));
    presc_d  = presc_q + 1'b1;
    idx_d    = idx_q;
    if (presc_tc) begin
      presc_d = '0;
      idx_d   = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it hold 0.
  always_comb begin : lz_calc
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (value_q[4*k +: 4] == 4'h0);
      lz_mask[k] = upper_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    nibble_sel = '0;
    dp_sel     = 1'b0;
    blank_sel  = 1'b0;
    lz_sel     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        nibble_sel = value_q[4*k +: 4];
        dp_sel     = dp_q[k];
        blank_sel  = blank_q[k];
        lz_sel     = lz_mask[k];
      end
    end
  end

  fnd_hex_font u_hex_font (
    .i_nibble (nibble_sel),
    .o_font   (hex_font)
  );

  // Explicit blank kills the dp as well; a suppressed leading zero keeps it.
  always_comb begin
    com_d  = '1;
    font_d = FND_FONT_BLANK;
    if (presc_q >= PRESC_W'(DEAD_CYCLES)) begin
      com_d = ~(NUM_DIGITS'(1) << idx_q);
      if (blank_sel) begin
        font_d = FND_FONT_BLANK;
      end else if (lz_sel) begin
        font_d         = FND_FONT_BLANK;
        font_d[DP_BIT] = ~dp_sel;
      end else begin
        font_d = hex_font;
        if (dp_sel) font_d[DP_BIT] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      com_q   <= '1;
      font_q  <= FND_FONT_BLANK;
    end else begin
      value_q <= value_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      com_q   <= com_d;
      font_q  <= font_d;
    end
  end

  assign o_fndCom   = com_q;
  assign o_fndFont  = font_q;
  assign o_digitIdx = idx_q;

endmodule
